// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into 3x3 "valid" convolution
// windows with output coordinates, using two row line buffers and a 3x3 tap array.
module conv_window_gen #(
    parameter int unsigned W       = 28,
    parameter int unsigned H       = 28,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COORD_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  win0,
    output logic [DATA_W-1:0]  win1,
    output logic [DATA_W-1:0]  win2,
    output logic [DATA_W-1:0]  win3,
    output logic [DATA_W-1:0]  win4,
    output logic [DATA_W-1:0]  win5,
    output logic [DATA_W-1:0]  win6,
    output logic [DATA_W-1:0]  win7,
    output logic [DATA_W-1:0]  win8,
    output logic [COORD_W-1:0] out_i,
    output logic [COORD_W-1:0] out_j,
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(H - 1);
    localparam logic [COORD_W-1:0] COORD_2  = COORD_W'(2);
    localparam logic [COORD_W-1:0] COORD_1  = COORD_W'(1);

    // Line buffers: lb1 holds the previous row, lb0 the row before it.
    logic [DATA_W-1:0] lb0 [W];
    logic [DATA_W-1:0] lb1 [W];

    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row_nxt;
    logic [COORD_W-1:0] col_nxt;
    logic               accept;
    logic               col_end;
    logic               row_end;
    logic               win_ok;
    logic [DATA_W-1:0]  lb0_rd;
    logic [DATA_W-1:0]  lb1_rd;

    // Upstream may push whenever the output register is free or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Old line-buffer contents at the current column form the new right tap column.
    assign lb0_rd = lb0[col];
    assign lb1_rd = lb1[col];

    // Raster position bookkeeping and window-validity decode.
    always_comb begin
        col_end = 1'b0;
        row_end = 1'b0;
        col_nxt = col;
        row_nxt = row;
        win_ok  = 1'b0;

        col_end = (col == COL_LAST);
        row_end = (row == ROW_LAST);
        win_ok  = (row >= COORD_2) && (col >= COORD_2);
        if (col_end) begin
            col_nxt = '0;
            row_nxt = row_end ? '0 : (row + COORD_1);
        end else begin
            col_nxt = col + COORD_1;
        end
    end

    // Line buffer update: the new pixel enters lb1, its displaced value ages into lb0.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= in_data;
            lb0[col] <= lb1_rd;
        end
    end

    // Position counters; restart at pixel (0,0) after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            row <= row_nxt;
            col <= col_nxt;
        end
    end

    // Tap array shifts left one column per accepted pixel; taps double as outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win0 <= '0;
            win1 <= '0;
            win2 <= '0;
            win3 <= '0;
            win4 <= '0;
            win5 <= '0;
            win6 <= '0;
            win7 <= '0;
            win8 <= '0;
        end else if (accept) begin
            win0 <= win1;
            win1 <= win2;
            win2 <= lb0_rd;
            win3 <= win4;
            win4 <= win5;
            win5 <= lb1_rd;
            win6 <= win7;
            win7 <= win8;
            win8 <= in_data;
        end
    end

    // Output qualifier, coordinates and end-of-frame flag, held under backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_i      <= '0;
            out_j      <= '0;
            frame_done <= 1'b0;
        end else if (accept) begin
            out_valid  <= win_ok;
            out_i      <= row - COORD_2;
            out_j      <= col - COORD_2;
            frame_done <= row_end && col_end;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: randomized stimulus, image-array reference model and
// queue scoreboard for conv_window_gen.
module tb_conv_window_gen;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NWIN = (H - 2) * (W - 2);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] win [9];
    logic [4:0] out_i;
    logic [4:0] out_j;
    logic       frame_done;

    conv_window_gen #(.W(W), .H(H), .DATA_W(8), .COORD_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .win0(win[0]), .win1(win[1]), .win2(win[2]),
        .win3(win[3]), .win4(win[4]), .win5(win[5]),
        .win6(win[6]), .win7(win[7]), .win8(win[8]),
        .out_i(out_i), .out_j(out_j), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Expected window: {frame_done, out_i, out_j, tap8 .. tap0} plus accept cycle.
    typedef struct {
        int          acc;
        logic [82:0] v;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  img [H][W];
    int          mr = 0;
    int          mc = 0;
    int          pmode = 0;
    int          win_cnt = 0;
    int          fd_cnt = 0;
    int          stall_run = 0;
    int          stall_tot = 0;
    bit          first_seen = 0;
    logic [82:0] cap_first = '0;
    logic [82:0] cap_last = '0;
    logic [82:0] cap35 = '0;
    logic [82:0] snap = '0;
    logic [82:0] a_mon;
    exp_t        e_mon;
    bit          bp_arm = 0;
    int          bp_cnt = 0;
    bit          rdy_rand = 0;

    always @(posedge clk) cyc++;

    function automatic logic [82:0] act();
        logic [82:0] v;
        v = {frame_done, out_i, out_j, 72'd0};
        for (int k = 0; k < 9; k++) v[k*8 +: 8] = win[k];
        return v;
    endfunction

    function automatic logic [82:0] mk(input logic [71:0] t, input int i, input int j, input bit fd);
        return {fd, 5'(i), 5'(j), t};
    endfunction

    task automatic chk(input string name, input logic [82:0] got, input logic [82:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] px(input int mode, input int r, input int c);
        case (mode)
            0:       return 8'((r + c) % 64);
            1:       return (r == 5 && c == 7) ? 8'h7f : 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    // Reference model: store the frame, emit a window from the stored image.
    task automatic model_accept(input logic [7:0] d);
        exp_t        e;
        logic [71:0] t;
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                    t[(a*3+b)*8 +: 8] = img[mr-2+a][mc-2+b];
            e.acc = cyc;
            e.v   = mk(t, mr - 2, mc - 2, (mr == H-1) && (mc == W-1));
            q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    // Offer pixels until n are accepted; bub is the per-cycle bubble percentage.
    task automatic feed(input int n, input int bub);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 20000) begin
            in_valid = (bub == 0) ? 1'b1 : ($urandom_range(99) >= bub);
            in_data  = px(pmode, mr, mc);
            @(negedge clk);
            if (in_valid && in_ready) begin
                model_accept(in_data);
                k++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (k < n) begin
            total++;
            bad++;
            $display("FAIL feed_timeout got=%0d want=%0d accepted", k, n);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got=%0d want=0 pending", q.size());
        end
    endtask

    task automatic clear_stats();
        win_cnt    = 0;
        fd_cnt     = 0;
        stall_tot  = 0;
        stall_run  = 0;
        first_seen = 0;
        cap35      = '0;
    endtask

    // Downstream readiness: always ready, random, or a 10-cycle stall at first window.
    always @(posedge clk) begin
        #1;
        if (bp_arm && out_valid) begin
            bp_arm = 0;
            bp_cnt = 10;
        end
        if (bp_cnt > 0) begin
            out_ready = 1'b0;
            bp_cnt--;
        end else begin
            out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
        end
    end

    // Monitor: stall stability checks and scoreboard comparison on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            a_mon = act();
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", 83'(in_ready), 83'd0);
                if (stall_run > 0) chk("stall_hold", a_mon, snap);
                snap = a_mon;
                stall_run++;
                stall_tot++;
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_window got=%h want=none", a_mon);
                end else begin
                    e_mon = q.pop_front();
                    chk("window", a_mon, e_mon.v);
                    chk("latency", 83'(cyc - stall_run), 83'(e_mon.acc + 1));
                end
                win_cnt++;
                if (frame_done) fd_cnt++;
                if (!first_seen) begin
                    cap_first  = a_mon;
                    first_seen = 1;
                end
                cap_last = a_mon;
                if (out_i == 5'd3 && out_j == 5'd5) cap35 = a_mon;
                stall_run = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] t_first;
        logic [71:0] t_last;
        logic [71:0] t_sig;
        t_first = {8'd4, 8'd3, 8'd2, 8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd0};
        t_last  = {8'd54, 8'd53, 8'd52, 8'd53, 8'd52, 8'd51, 8'd52, 8'd51, 8'd50};
        t_sig   = {8'h7f, {8{8'h80}}};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", act(), 83'd0);
        chk("reset_valid", 83'(out_valid), 83'd0);
        chk("reset_in_ready", 83'(in_ready), 83'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Ramp frame at full rate.
        clear_stats();
        pmode = 0;
        feed(H * W, 0);
        drain();
        chk("ramp_count", 83'(win_cnt), 83'(NWIN));
        chk("ramp_frame_done_count", 83'(fd_cnt), 83'd1);
        chk("ramp_first", cap_first, mk(t_first, 0, 0, 1'b0));
        chk("ramp_last", cap_last, mk(t_last, 25, 25, 1'b1));

        // Signed extremes.
        clear_stats();
        pmode = 1;
        feed(H * W, 0);
        drain();
        chk("signed_count", 83'(win_cnt), 83'(NWIN));
        chk("signed_win_3_5", cap35, mk(t_sig, 3, 5, 1'b0));

        // Ten-cycle backpressure at the first window.
        clear_stats();
        pmode  = 0;
        bp_arm = 1;
        feed(H * W, 0);
        drain();
        chk("bp_count", 83'(win_cnt), 83'(NWIN));
        chk("bp_stall_cycles", 83'(stall_tot), 83'd10);
        chk("bp_first", cap_first, mk(t_first, 0, 0, 1'b0));

        // Input bubbles with random downstream readiness.
        clear_stats();
        pmode    = 0;
        rdy_rand = 1;
        feed(H * W, 50);
        drain();
        rdy_rand = 0;
        @(posedge clk);
        #1;
        chk("bubble_count", 83'(win_cnt), 83'(NWIN));
        chk("bubble_first", cap_first, mk(t_first, 0, 0, 1'b0));
        chk("bubble_last", cap_last, mk(t_last, 25, 25, 1'b1));

        // Two frames back to back.
        clear_stats();
        pmode = 2;
        feed(2 * H * W, 0);
        drain();
        chk("b2b_count", 83'(win_cnt), 83'(2 * NWIN));
        chk("b2b_frame_done_count", 83'(fd_cnt), 83'd2);

        // Mid-frame asynchronous reset, then a full frame.
        clear_stats();
        pmode = 2;
        feed(100, 0);
        #2;
        chk("pre_reset_valid", 83'(out_valid), 83'd1);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", act(), 83'd0);
        chk("midrst_valid", 83'(out_valid), 83'd0);
        chk("midrst_in_ready", 83'(in_ready), 83'd1);
        q.delete();
        mr = 0;
        mc = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_stats();
        feed(H * W, 0);
        drain();
        chk("midrst_count", 83'(win_cnt), 83'(NWIN));
        chk("midrst_frame_done_count", 83'(fd_cnt), 83'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
